// File: rtl/vrased_reset_ctrl.sv
// Merges VRASED monitor violation requests into one stretched PUC request.
// The request is held until the CPU reaches the reset handler. Cause and count diagnostics are kept for firmware.
module vrased_reset_ctrl #(
  parameter int unsigned NUM_SRC        = 4,
  parameter int unsigned STRETCH_CYCLES = 8,
  parameter logic [15:0] RESET_HANDLER  = 16'hFFFE,
  parameter int unsigned CNT_W          = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [15:0]        pc,
  input  logic [NUM_SRC-1:0] viol_req,
  input  logic               cause_clr,
  output logic               puc_req,
  output logic               busy,
  output logic [NUM_SRC-1:0] cause,
  output logic [NUM_SRC-1:0] first_cause,
  output logic [CNT_W-1:0]   viol_cnt
);

  localparam int unsigned SW = (STRETCH_CYCLES > 1) ? $clog2(STRETCH_CYCLES) : 1;
  localparam logic [SW-1:0] RELOAD = SW'(STRETCH_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, STRETCH, HOLD} state_t;

  state_t             state, state_n;
  logic [SW-1:0]      cnt, cnt_n;
  logic               hs, hs_n;
  logic [NUM_SRC-1:0] cause_n, first_n;
  logic [CNT_W-1:0]   vcnt_n;
  logic               start, clr_win;
  logic               any_viol, at_handler;

  assign any_viol   = |viol_req;
  assign at_handler = (pc == RESET_HANDLER);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    hs_n    = hs;
    cause_n = cause;
    first_n = first_cause;
    vcnt_n  = viol_cnt;
    start   = 1'b0;
    clr_win = 1'b0;
    case (state)
      IDLE: begin
        if (any_viol) begin
          start   = 1'b1;
          clr_win = cause_clr;
        end else if (cause_clr) begin
          cause_n = '0;
          first_n = '0;
          vcnt_n  = '0;
        end
      end
      STRETCH: begin
        cause_n = cause | viol_req;
        // The last stretch edge applies the hold-exit rule directly, so an early handler adds no extra cycle.
        if (cnt == '0) begin
          if (hs || at_handler) begin
            if (any_viol) start = 1'b1;
            else          state_n = IDLE;
          end else begin
            state_n = HOLD;
          end
        end else begin
          cnt_n = cnt - 1'b1;
          if (at_handler) hs_n = 1'b1;
        end
      end
      HOLD: begin
        cause_n = cause | viol_req;
        if (hs || at_handler) begin
          if (any_viol) start = 1'b1;
          else          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    if (start) begin
      state_n = STRETCH;
      cnt_n   = RELOAD;
      hs_n    = 1'b0;
      first_n = viol_req;
      if (clr_win) begin
        cause_n = viol_req;
        vcnt_n  = CNT_W'(1);
      end else begin
        cause_n = cause | viol_req;
        vcnt_n  = (&viol_cnt) ? viol_cnt : viol_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      cnt         <= '0;
      hs          <= 1'b0;
      cause       <= '0;
      first_cause <= '0;
      viol_cnt    <= '0;
      puc_req     <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      hs          <= hs_n;
      cause       <= cause_n;
      first_cause <= first_n;
      viol_cnt    <= vcnt_n;
      puc_req     <= (state_n != IDLE);
      busy        <= (state_n != IDLE);
    end
  end

endmodule

// File: tb/tb_vrased_reset_ctrl.sv
// Bench for vrased_reset_ctrl: default instance plus a STRETCH_CYCLES=1, CNT_W=2 instance on shared stimulus.
// Each instance is compared every cycle against an episode-level model.
module tb_vrased_reset_ctrl;
  localparam logic [15:0] RH = 16'hFFFE;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] pc = 16'hE000;
  logic [3:0]  viol = '0;
  logic        clr = 1'b0;

  logic       a_puc, a_busy, b_puc, b_busy;
  logic [3:0] a_cause, a_first, b_cause, b_first;
  logic [7:0] a_cnt;
  logic [1:0] b_cnt;

  int total = 0;
  int bad = 0;

  vrased_reset_ctrl dut_a (
    .clk(clk), .reset_n(reset_n), .pc(pc), .viol_req(viol), .cause_clr(clr),
    .puc_req(a_puc), .busy(a_busy), .cause(a_cause), .first_cause(a_first), .viol_cnt(a_cnt)
  );

  vrased_reset_ctrl #(.NUM_SRC(4), .STRETCH_CYCLES(1), .RESET_HANDLER(16'hFFFE), .CNT_W(2)) dut_b (
    .clk(clk), .reset_n(reset_n), .pc(pc), .viol_req(viol), .cause_clr(clr),
    .puc_req(b_puc), .busy(b_busy), .cause(b_cause), .first_cause(b_first), .viol_cnt(b_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // k counts edges since the latest episode entry; the request may drop once k reaches the stretch length.
  typedef struct {
    bit         active;
    int         k;
    bit         seen;
    logic [3:0] cause;
    logic [3:0] first;
    int         cnt;
  } model_t;

  model_t ma, mb;

  function automatic model_t step(model_t m, logic [3:0] v, logic [15:0] p, logic c,
                                  int s, int maxc);
    model_t n = m;
    int e;
    if (!m.active) begin
      if (v != 0) begin
        n.active = 1; n.k = 0; n.seen = 0; n.first = v;
        n.cause  = c ? v : (m.cause | v);
        n.cnt    = c ? 1 : ((m.cnt < maxc) ? m.cnt + 1 : maxc);
      end else if (c) begin
        n.cause = 0; n.first = 0; n.cnt = 0;
      end
    end else begin
      n.cause = m.cause | v;
      e = m.k + 1;
      if (e >= s && (m.seen || p == RH)) begin
        if (v != 0) begin
          n.k = 0; n.seen = 0; n.first = v;
          n.cnt = (m.cnt < maxc) ? m.cnt + 1 : maxc;
        end else begin
          n.active = 0;
        end
      end else begin
        n.k = (e > s) ? s : e;
        if (p == RH) n.seen = 1;
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ma = '{default: '0};
      mb = '{default: '0};
    end else begin
      ma = step(ma, viol, pc, clr, 8, 255);
      mb = step(mb, viol, pc, clr, 1, 3);
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      chk("a_puc",   32'(a_puc),   32'(ma.active));
      chk("a_busy",  32'(a_busy),  32'(ma.active));
      chk("a_cause", 32'(a_cause), 32'(ma.cause));
      chk("a_first", 32'(a_first), 32'(ma.first));
      chk("a_cnt",   32'(a_cnt),   32'(ma.cnt));
      chk("b_puc",   32'(b_puc),   32'(mb.active));
      chk("b_busy",  32'(b_busy),  32'(mb.active));
      chk("b_cause", 32'(b_cause), 32'(mb.cause));
      chk("b_first", 32'(b_first), 32'(mb.first));
      chk("b_cnt",   32'(b_cnt),   32'(mb.cnt));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #3;
    chk("rst_puc",   32'(a_puc),   0);
    chk("rst_busy",  32'(a_busy),  0);
    chk("rst_cause", 32'(a_cause), 0);
    chk("rst_first", 32'(a_first), 0);
    chk("rst_cnt",   32'(a_cnt),   0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) tick();

    // basic episode, handler reached late
    viol = 4'b0001; tick(); viol = '0;
    chk("t1_latency", 32'(a_puc), 1);
    repeat (15) tick();
    chk("t1_still_high", 32'(a_puc), 1);
    pc = RH; tick();
    chk("t1_release", 32'(a_puc), 0);
    chk("t1_cause", 32'(a_cause), 32'h1);
    chk("t1_first", 32'(a_first), 32'h1);
    chk("t1_cnt", 32'(a_cnt), 1);

    // early handler: exactly eight cycles high
    pc = 16'hE000; tick();
    viol = 4'b0001; tick(); viol = '0; pc = RH;
    repeat (7) tick();
    chk("t2_last_high", 32'(a_puc), 1);
    tick();
    chk("t2_low", 32'(a_puc), 0);
    chk("t2_cnt", 32'(a_cnt), 2);

    // multi-source and clear handling
    pc = 16'hE000; clr = 1'b1; tick(); clr = 1'b0;
    chk("t5_clr_cause", 32'(a_cause), 0);
    chk("t5_clr_cnt", 32'(a_cnt), 0);
    viol = 4'b0010; tick(); viol = '0;
    repeat (9) tick();
    viol = 4'b1000; tick(); viol = '0;
    chk("t4_cause", 32'(a_cause), 32'hA);
    chk("t4_first", 32'(a_first), 32'h2);
    chk("t4_cnt", 32'(a_cnt), 1);
    chk("t4_busy", 32'(a_busy), 1);
    clr = 1'b1; tick(); clr = 1'b0;
    chk("t5_busy_clr_ignored", 32'(a_cause), 32'hA);
    pc = RH; tick();
    chk("t4_idle", 32'(a_busy), 0);
    pc = 16'hE000;
    clr = 1'b1; viol = 4'b0100; tick(); clr = 1'b0; viol = '0;
    chk("t5_win_cause", 32'(a_cause), 32'h4);
    chk("t5_win_first", 32'(a_first), 32'h4);
    chk("t5_win_cnt", 32'(a_cnt), 1);
    pc = RH; repeat (8) tick();
    chk("t5_idle", 32'(a_busy), 0);
    pc = 16'hE000; clr = 1'b1; tick(); clr = 1'b0;
    chk("t5_zero_cause", 32'(a_cause), 0);
    chk("t5_zero_first", 32'(a_first), 0);
    chk("t5_zero_cnt", 32'(a_cnt), 0);

    // persistent violation re-enters with no gap; small counter saturates
    viol = 4'b0001; pc = RH; tick();
    chk("t3_cnt1", 32'(a_cnt), 1);
    repeat (8) tick();
    chk("t3_cnt2", 32'(a_cnt), 2);
    chk("t3_no_gap", 32'(a_puc), 1);
    chk("t6_sat", 32'(b_cnt), 3);
    viol = '0; repeat (8) tick();
    chk("t3_idle", 32'(a_busy), 0);

    // asynchronous reset mid-stretch
    pc = 16'hE000; viol = 4'b0001; tick(); viol = '0; tick();
    #2 reset_n = 1'b0;
    #1;
    chk("t6_async_puc", 32'(a_puc), 0);
    chk("t6_async_busy", 32'(a_busy), 0);
    chk("t6_async_cnt", 32'(a_cnt), 0);
    chk("t6_async_b_puc", 32'(b_puc), 0);
    @(negedge clk);
    reset_n = 1'b1;

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      viol = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0000;
      pc   = ($urandom_range(0, 3) == 0) ? RH : 16'($urandom);
      clr  = ($urandom_range(0, 15) == 0);
      tick();
      if ($urandom_range(0, 499) == 0) begin
        #2 reset_n = 1'b0;
        #1;
        chk("rnd_async_puc", 32'(a_puc), 0);
        @(negedge clk);
        reset_n = 1'b1;
      end
    end
    viol = '0; clr = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
